// File: rtl/sample_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sample_ram_arbiter
// Description : Two-master to one-slave pipelined Wishbone arbiter placed in
//               front of port A of the sample RAM.
//               Master 0 is the sniffer capture path (write-only, latency
//               critical) and has fixed priority. Master 1 is the readout path
//               and is protected from starvation by a burst counter.
//               Ownership only moves while nothing is outstanding, so slave
//               acks are routed to the owner without any tagging.
// Ports       : clk_i / rst_i         clock, asynchronous active-low reset
//               m0_*_i / m0_*_o       master 0 request, stall and ack
//               m1_*_i / m1_*_o       master 1 request, stall and ack
//               m_data_o              shared read data (valid with an ack)
//               s_*_o / s_*_i         slave request, stall, ack and read data
//               spurious_ack_o        pulse for an ack with nothing outstanding
// Revision    : 1.0 - initial release
// ============================================================================
module sample_ram_arbiter #(
  parameter int ADDR_W          = 32,
  parameter int MAX_BURST       = 16,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] m0_addr_i,
  input  logic [31:0]       m0_data_i,
  input  logic [3:0]        m0_sel_i,
  input  logic              m0_we_i,
  input  logic              m0_stb_i,
  output logic              m0_stall_o,
  output logic              m0_ack_o,
  input  logic [ADDR_W-1:0] m1_addr_i,
  input  logic [31:0]       m1_data_i,
  input  logic [3:0]        m1_sel_i,
  input  logic              m1_we_i,
  input  logic              m1_stb_i,
  output logic              m1_stall_o,
  output logic              m1_ack_o,
  output logic [31:0]       m_data_o,
  output logic [ADDR_W-1:0] s_addr_o,
  output logic [31:0]       s_data_o,
  output logic [3:0]        s_sel_o,
  output logic              s_we_o,
  output logic              s_stb_o,
  input  logic              s_stall_i,
  input  logic              s_ack_i,
  input  logic [31:0]       s_data_i,
  output logic              spurious_ack_o
);

  localparam logic [7:0] BURST_LIM = 8'(MAX_BURST);
  localparam logic [3:0] OUTST_LIM = 4'(MAX_OUTSTANDING);

  logic       owner_q, owner_d;
  logic [3:0] outstanding_q, outstanding_d;
  logic [7:0] burst_q, burst_d;
  // live_q is cleared asynchronously by reset and set on the first clock edge
  // after release; it forces the reset output values in between.
  logic       live_q, live_d;

  logic cur_owner;
  logic idle;
  logic burst_full;
  logic limit_block;
  logic starve_block;
  logic block;
  logic owner_stb;
  logic accept;
  logic ack_ok;

  // State register
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      owner_q       <= 1'b0;
      outstanding_q <= 4'd0;
      burst_q       <= 8'd0;
      live_q        <= 1'b0;
    end else begin
      owner_q       <= owner_d;
      outstanding_q <= outstanding_d;
      burst_q       <= burst_d;
      live_q        <= live_d;
    end
  end

  // Arbitration: the effective owner this cycle. On a switch cycle the new
  // winner drives the slave immediately, so there is no added latency.
  always_comb begin
    idle       = (outstanding_q == 4'd0);
    burst_full = (burst_q >= BURST_LIM);
    cur_owner  = owner_q;
    if (live_q && idle) begin
      if (m1_stb_i && (!m0_stb_i || burst_full)) begin
        cur_owner = 1'b1;
      end else if (m0_stb_i) begin
        cur_owner = 1'b0;
      end
    end
  end

  // Outputs
  always_comb begin
    // At the limit an ack arriving this cycle frees a slot for a new accept.
    limit_block  = (outstanding_q == OUTST_LIM) && !s_ack_i;
    // Stall master 0 even with transactions in flight so they can drain and
    // master 1 wins the next arbitration.
    starve_block = !cur_owner && m1_stb_i && burst_full;
    block        = !live_q || limit_block || starve_block;
    owner_stb    = cur_owner ? m1_stb_i : m0_stb_i;

    s_stb_o    = owner_stb && !block;
    accept     = s_stb_o && !s_stall_i;
    m0_stall_o = cur_owner  ? 1'b1 : (block || s_stall_i);
    m1_stall_o = !cur_owner ? 1'b1 : (block || s_stall_i);

    s_addr_o = cur_owner ? m1_addr_i : m0_addr_i;
    s_data_o = cur_owner ? m1_data_i : m0_data_i;
    s_sel_o  = cur_owner ? m1_sel_i  : m0_sel_i;
    s_we_o   = cur_owner ? m1_we_i   : m0_we_i;

    // An ack with nothing outstanding is dropped and only flagged.
    ack_ok         = live_q && s_ack_i && !idle;
    m0_ack_o       = ack_ok && !owner_q;
    m1_ack_o       = ack_ok && owner_q;
    spurious_ack_o = live_q && s_ack_i && idle;
    m_data_o       = s_data_i;
  end

  // Next state
  always_comb begin
    owner_d       = cur_owner;
    outstanding_d = outstanding_q + {3'd0, accept} - {3'd0, ack_ok};
    burst_d       = burst_q;
    if (!m1_stb_i || (accept && cur_owner)) begin
      burst_d = 8'd0;
    end else if (accept && !cur_owner && !burst_full) begin
      burst_d = burst_q + 8'd1;
    end
    live_d = 1'b1;
  end

endmodule
`default_nettype wire

// File: tb/tb_sample_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_sample_ram_arbiter
// Description : Directed self-checking bench for sample_ram_arbiter with
//               MAX_BURST=4 and MAX_OUTSTANDING=4. Inputs change 1 time unit
//               after the rising edge; registered behaviour is sampled on the
//               falling edge.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sample_ram_arbiter;

  localparam int ADDR_W = 32;

  logic              clk_i = 1'b0;
  logic              rst_i = 1'b0;
  logic [ADDR_W-1:0] m0_addr_i = '0;
  logic [31:0]       m0_data_i = '0;
  logic [3:0]        m0_sel_i  = '0;
  logic              m0_we_i   = 1'b0;
  logic              m0_stb_i  = 1'b0;
  logic              m0_stall_o;
  logic              m0_ack_o;
  logic [ADDR_W-1:0] m1_addr_i = '0;
  logic [31:0]       m1_data_i = '0;
  logic [3:0]        m1_sel_i  = '0;
  logic              m1_we_i   = 1'b0;
  logic              m1_stb_i  = 1'b0;
  logic              m1_stall_o;
  logic              m1_ack_o;
  logic [31:0]       m_data_o;
  logic [ADDR_W-1:0] s_addr_o;
  logic [31:0]       s_data_o;
  logic [3:0]        s_sel_o;
  logic              s_we_o;
  logic              s_stb_o;
  logic              s_stall_i = 1'b0;
  logic              s_ack_i   = 1'b0;
  logic [31:0]       s_data_i  = '0;
  logic              spurious_ack_o;

  sample_ram_arbiter #(
    .ADDR_W         (ADDR_W),
    .MAX_BURST      (4),
    .MAX_OUTSTANDING(4)
  ) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .m0_addr_i     (m0_addr_i),
    .m0_data_i     (m0_data_i),
    .m0_sel_i      (m0_sel_i),
    .m0_we_i       (m0_we_i),
    .m0_stb_i      (m0_stb_i),
    .m0_stall_o    (m0_stall_o),
    .m0_ack_o      (m0_ack_o),
    .m1_addr_i     (m1_addr_i),
    .m1_data_i     (m1_data_i),
    .m1_sel_i      (m1_sel_i),
    .m1_we_i       (m1_we_i),
    .m1_stb_i      (m1_stb_i),
    .m1_stall_o    (m1_stall_o),
    .m1_ack_o      (m1_ack_o),
    .m_data_o      (m_data_o),
    .s_addr_o      (s_addr_o),
    .s_data_o      (s_data_o),
    .s_sel_o       (s_sel_o),
    .s_we_o        (s_we_o),
    .s_stb_o       (s_stb_o),
    .s_stall_i     (s_stall_i),
    .s_ack_i       (s_ack_i),
    .s_data_i      (s_data_i),
    .spurious_ack_o(spurious_ack_o)
  );

  always #5 clk_i = ~clk_i;

  int checks   = 0;
  int failures = 0;

  // Per-cycle samples and running tallies
  logic acc0, acc1, ack0, ack1, spur, sstb;
  int   n_acc0, n_acc1, n_ack0, n_ack1, n_spur, n_stall0;
  int   cyc = 0;
  int   samp = 0;
  logic auto_ack = 1'b0;

  task automatic clear_tally();
    n_acc0 = 0; n_acc1 = 0; n_ack0 = 0; n_ack1 = 0; n_spur = 0; n_stall0 = 0;
  endtask

  // Sample one cycle at the falling edge, then advance to just after the next
  // rising edge. With auto_ack the slave acks one cycle after each accept.
  task automatic cycle();
    @(negedge clk_i);
    acc0 = m0_stb_i && !m0_stall_o;
    acc1 = m1_stb_i && !m1_stall_o;
    ack0 = m0_ack_o;
    ack1 = m1_ack_o;
    spur = spurious_ack_o;
    sstb = s_stb_o;
    if (acc0) n_acc0++;
    if (acc1) n_acc1++;
    if (ack0) n_ack0++;
    if (ack1) n_ack1++;
    if (spur) n_spur++;
    if (m0_stb_i && m0_stall_o) n_stall0++;
    samp = cyc;
    cyc++;
    @(posedge clk_i);
    #1;
    if (auto_ack) s_ack_i = acc0 | acc1;
  endtask

  task automatic test_reset();
    rst_i = 1'b0; m0_stb_i = 1'b1; m1_stb_i = 1'b1; s_ack_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    checks++; if (s_stb_o !== 1'b0) begin failures++; $display("FAIL rst_s_stb got=%b exp=0", s_stb_o); end
    checks++; if (m0_stall_o !== 1'b1) begin failures++; $display("FAIL rst_m0_stall got=%b exp=1", m0_stall_o); end
    checks++; if (m1_stall_o !== 1'b1) begin failures++; $display("FAIL rst_m1_stall got=%b exp=1", m1_stall_o); end
    checks++; if (m0_ack_o !== 1'b0 || m1_ack_o !== 1'b0) begin failures++; $display("FAIL rst_acks got=%b%b exp=00", m0_ack_o, m1_ack_o); end
    checks++; if (spurious_ack_o !== 1'b0) begin failures++; $display("FAIL rst_spur got=%b exp=0", spurious_ack_o); end
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++; if (m0_stall_o !== 1'b1 || s_stb_o !== 1'b0) begin failures++; $display("FAIL rst_release_before_edge stall=%b stb=%b exp stall=1 stb=0", m0_stall_o, s_stb_o); end
    @(posedge clk_i);
    #1;
    checks++; if (m0_stall_o !== 1'b0 || s_stb_o !== 1'b1) begin failures++; $display("FAIL rst_release_after_edge stall=%b stb=%b exp stall=0 stb=1", m0_stall_o, s_stb_o); end
    checks++; if (spurious_ack_o !== 1'b1) begin failures++; $display("FAIL rst_release_spur got=%b exp=1", spurious_ack_o); end
    m0_stb_i = 1'b0; m1_stb_i = 1'b0; s_ack_i = 1'b0;
    repeat (2) cycle();
  endtask

  task automatic test_m0_stream();
    clear_tally();
    auto_ack = 1'b1;
    for (int i = 0; i < 8; i++) begin
      m0_stb_i  = 1'b1;
      m0_we_i   = 1'b1;
      m0_sel_i  = 4'hF;
      m0_addr_i = 32'h100 + 32'(i * 4);
      m0_data_i = 32'hA000_0000 | 32'(i);
      #1;
      if (i == 3) begin
        checks++;
        if (s_addr_o !== 32'h10C || s_data_o !== 32'hA000_0003 || s_we_o !== 1'b1 || s_sel_o !== 4'hF) begin
          failures++; $display("FAIL m0_passthru addr=%h data=%h we=%b sel=%h exp 10c a0000003 1 f", s_addr_o, s_data_o, s_we_o, s_sel_o);
        end
      end
      cycle();
    end
    m0_stb_i = 1'b0; m0_we_i = 1'b0;
    repeat (3) cycle();
    checks++; if (n_acc0 != 8) begin failures++; $display("FAIL m0_stream_accepts got=%0d exp=8", n_acc0); end
    checks++; if (n_ack0 != 8) begin failures++; $display("FAIL m0_stream_acks got=%0d exp=8", n_ack0); end
    checks++; if (n_ack1 != 0) begin failures++; $display("FAIL m0_stream_m1_acks got=%0d exp=0", n_ack1); end
    checks++; if (n_stall0 != 0) begin failures++; $display("FAIL m0_stream_stalls got=%0d exp=0", n_stall0); end
  endtask

  // Both masters request continuously; master 1 re-requests one cycle after
  // each of its accepts. Expect 4 master-0 accepts between master-1 accepts
  // and master-1 wait <= MAX_BURST+MAX_OUTSTANDING+2 = 10 cycles.
  task automatic test_starvation();
    int run;
    int n_m1;
    int req_start;
    clear_tally();
    auto_ack = 1'b1;
    m0_stb_i = 1'b1; m0_we_i = 1'b1;
    m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h200;
    run = 0; n_m1 = 0; req_start = cyc;
    for (int k = 0; k < 80 && n_m1 < 3; k++) begin
      cycle();
      if (acc0) run++;
      if (acc1) begin
        checks++; if (run != 4) begin failures++; $display("FAIL starve_burst_run got=%0d exp=4", run); end
        checks++; if (samp - req_start > 10) begin failures++; $display("FAIL starve_m1_latency got=%0d exp<=10", samp - req_start); end
        run = 0;
        n_m1++;
        m1_stb_i = 1'b0;
      end else if (!m1_stb_i) begin
        m1_stb_i = 1'b1;
        req_start = cyc;
      end
    end
    checks++; if (n_m1 != 3) begin failures++; $display("FAIL starve_m1_count got=%0d exp=3", n_m1); end
    m0_stb_i = 1'b0; m1_stb_i = 1'b0; m0_we_i = 1'b0;
    repeat (4) cycle();
  endtask

  task automatic test_outstanding_limit();
    clear_tally();
    auto_ack = 1'b0;
    s_ack_i = 1'b0;
    m0_stb_i = 1'b1; m0_we_i = 1'b1;
    repeat (4) cycle();
    checks++; if (n_acc0 != 4) begin failures++; $display("FAIL limit_accepts got=%0d exp=4", n_acc0); end
    cycle();
    checks++; if (acc0 !== 1'b0 || sstb !== 1'b0) begin failures++; $display("FAIL limit_block acc=%b stb=%b exp 0 0", acc0, sstb); end
    s_ack_i = 1'b1;
    cycle();
    checks++; if (acc0 !== 1'b1 || ack0 !== 1'b1) begin failures++; $display("FAIL limit_ack_accept acc=%b ack=%b exp 1 1", acc0, ack0); end
    s_ack_i = 1'b0;
    cycle();
    checks++; if (acc0 !== 1'b0) begin failures++; $display("FAIL limit_reblock acc=%b exp=0", acc0); end
    m0_stb_i = 1'b0; m0_we_i = 1'b0;
    s_ack_i = 1'b1;
    repeat (4) cycle();
    s_ack_i = 1'b0;
    checks++; if (n_ack0 != 5 || n_spur != 0) begin failures++; $display("FAIL limit_drain acks=%0d spur=%0d exp 5 0", n_ack0, n_spur); end
    cycle();
  endtask

  task automatic test_spurious();
    auto_ack = 1'b0;
    s_ack_i = 1'b1;
    cycle();
    checks++; if (spur !== 1'b1 || ack0 !== 1'b0 || ack1 !== 1'b0) begin failures++; $display("FAIL spur_pulse spur=%b acks=%b%b exp 1 00", spur, ack0, ack1); end
    s_ack_i = 1'b0;
    cycle();
    checks++; if (spur !== 1'b0) begin failures++; $display("FAIL spur_one_cycle got=%b exp=0", spur); end
    s_ack_i = 1'b1;
    cycle();
    checks++; if (spur !== 1'b1 || ack0 !== 1'b0) begin failures++; $display("FAIL spur_outst_zero spur=%b ack=%b exp 1 0", spur, ack0); end
    s_ack_i = 1'b0;
    cycle();
  endtask

  task automatic test_mid_reset();
    clear_tally();
    auto_ack = 1'b0;
    m0_stb_i = 1'b1; m0_we_i = 1'b1;
    repeat (3) cycle();
    checks++; if (n_acc0 != 3) begin failures++; $display("FAIL midrst_accepts got=%0d exp=3", n_acc0); end
    s_ack_i = 1'b1;
    #1;
    checks++; if (m0_ack_o !== 1'b1) begin failures++; $display("FAIL midrst_live_ack got=%b exp=1", m0_ack_o); end
    #1;
    rst_i = 1'b0;
    #1;
    checks++; if (m0_ack_o !== 1'b0 || s_stb_o !== 1'b0 || m0_stall_o !== 1'b1 || m1_stall_o !== 1'b1 || spurious_ack_o !== 1'b0) begin
      failures++; $display("FAIL midrst_async ack=%b stb=%b stall0=%b stall1=%b spur=%b exp 0 0 1 1 0", m0_ack_o, s_stb_o, m0_stall_o, m1_stall_o, spurious_ack_o);
    end
    s_ack_i = 1'b0;
    @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b1;
    #1;
    checks++; if (m0_stall_o !== 1'b1) begin failures++; $display("FAIL midrst_hold_until_edge got=%b exp=1", m0_stall_o); end
    @(posedge clk_i);
    #1;
    m0_stb_i = 1'b0; m0_we_i = 1'b0;
    clear_tally();
    s_ack_i = 1'b1;
    repeat (3) cycle();
    s_ack_i = 1'b0;
    checks++; if (n_spur != 3 || n_ack0 != 0 || n_ack1 != 0) begin failures++; $display("FAIL midrst_late_acks spur=%0d ack0=%0d ack1=%0d exp 3 0 0", n_spur, n_ack0, n_ack1); end
    cycle();
  endtask

  task automatic test_m1_read();
    auto_ack = 1'b0;
    m0_stb_i = 1'b0;
    m1_stb_i = 1'b1; m1_we_i = 1'b0; m1_addr_i = 32'h40; m1_sel_i = 4'hF;
    #1;
    checks++; if (s_addr_o !== 32'h40 || s_we_o !== 1'b0 || s_stb_o !== 1'b1 || m1_stall_o !== 1'b0) begin
      failures++; $display("FAIL m1_read_req addr=%h we=%b stb=%b stall=%b exp 40 0 1 0", s_addr_o, s_we_o, s_stb_o, m1_stall_o);
    end
    cycle();
    m1_stb_i = 1'b0;
    s_ack_i = 1'b1; s_data_i = 32'hDEAD_BEEF;
    #1;
    checks++; if (m1_ack_o !== 1'b1 || m0_ack_o !== 1'b0 || m_data_o !== 32'hDEAD_BEEF) begin
      failures++; $display("FAIL m1_read_ack ack1=%b ack0=%b data=%h exp 1 0 deadbeef", m1_ack_o, m0_ack_o, m_data_o);
    end
    cycle();
    s_ack_i = 1'b0; s_data_i = '0;
    cycle();
  endtask

  initial begin
    clear_tally();
    test_reset();
    test_m0_stream();
    test_starvation();
    test_outstanding_limit();
    test_spurious();
    test_mid_reset();
    test_m1_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/sample_ram_arbiter.md
Name: sample_ram_arbiter

Overview:
- Two-master to one-slave pipelined Wishbone arbiter in front of the sample RAM's port A.
- Master 0 is the USB sniffer capture path (write-only, latency-critical). Master 1 is the readout path, used by the host-side reader to fetch captured samples.
- Fixed priority to master 0, with a starvation guard for master 1.
- Ownership changes only when no transactions are outstanding, so acks are routed to the owning master without tags.

Parameters:
- ADDR_W, 32, address width of all address ports.
- MAX_BURST, 16, consecutive master-0 accepts allowed while master 1 is waiting; legal range 1..255.
- MAX_OUTSTANDING, 4, maximum accepted-but-unacked requests; legal range 1..15.

Ports:
- clk_i  in  1  sole clock, sniffer/ULPI 60 MHz domain.
- rst_i  in  1  asynchronous, active-low reset.
- m0_addr_i  in  ADDR_W  master 0 address.
- m0_data_i  in  32  master 0 write data.
- m0_sel_i  in  4  master 0 byte selects.
- m0_we_i  in  1  master 0 write enable.
- m0_stb_i  in  1  master 0 request.
- m0_stall_o  out  1  master 0 request not accepted this cycle.
- m0_ack_o  out  1  master 0 completion.
- m1_addr_i, m1_data_i, m1_sel_i, m1_we_i, m1_stb_i  in  as for m0  master 1 request.
- m1_stall_o  out  1  master 1 request not accepted this cycle.
- m1_ack_o  out  1  master 1 completion.
- m_data_o  out  32  read data, shared by both masters; valid only with the receiving master's ack.
- s_addr_o  out  ADDR_W  slave address.
- s_data_o  out  32  slave write data.
- s_sel_o  out  4  slave byte selects.
- s_we_o  out  1  slave write enable.
- s_stb_o  out  1  slave request.
- s_stall_i  in  1  slave stall.
- s_ack_i  in  1  slave completion.
- s_data_i  in  32  slave read data.
- spurious_ack_o  out  1  one-cycle pulse when s_ack_i arrives with zero outstanding.

Behaviour:
- **Reset (rst_i low, asynchronous):**
  - owner_q=0, outstanding_q=0, burst_q=0.
  - All stb/ack/spurious outputs 0; both stall outputs 1.
  - Outputs release on the first clk_i edge after rst_i deasserts.
- **Request acceptance:** a request is accepted when stb=1 and stall=0 in the same cycle (pipelined Wishbone). Address, data, sel and we pass combinationally to s_* from the owner (owner_q, or the new winner on a switch cycle). Zero added latency.
- **Arbitration:**
  - Evaluated only when outstanding_q==0.
  - If m1_stb_i and (m0_stb_i==0 or burst_q>=MAX_BURST): winner=1. Else if m0_stb_i: winner=0. Else owner_q holds.
  - The winner takes effect in the same cycle and owner_q<=winner.
- **Holding ownership:** while outstanding_q!=0, owner_q is frozen and the non-owner sees stall=1.
- **Starvation guard:** when owner_q==0, m1_stb_i==1 and burst_q>=MAX_BURST, master 0 is stalled, even at outstanding_q!=0. Outstanding requests then drain and master 1 wins.
- **burst_q:**
  - +1 on each master-0 accept while m1_stb_i==1, saturating at MAX_BURST.
  - Cleared on any cycle with m1_stb_i==0 or a master-1 accept.
- **Outstanding limit:** outstanding_q==MAX_OUTSTANDING and s_ack_i==0 gives owner stall=1 and s_stb_o=0. Outstanding at the limit with s_ack_i==1 in the same cycle allows an accept.
- **s_stb_o:** owner stb AND not internally blocked. Owner stall_o = internal block OR s_stall_i. Non-owner stall_o = 1.
- **outstanding_q:** next value = outstanding_q + accept − (s_ack_i and outstanding_q!=0). Simultaneous accept and ack leaves it unchanged.
- **Acks:**
  - s_ack_i is routed combinationally to owner_q's ack output.
  - With outstanding_q==0, s_ack_i is dropped, no master ack is raised, and spurious_ack_o=1 for one cycle.
- **Read data:** m_data_o = s_data_i, unregistered.
- **Mid-transaction reset:** outstanding state is discarded and later slave acks are treated as spurious.
- **Counter widths:**
  - outstanding_q is 4 bits.
  - burst_q is 8 bits.

Test Plan:
- Idle, then m0_stb_i held for 8 cycles; slave acks every next cycle, no stall. Required: 8 s_stb_o beats, 8 m0_ack_o, m1_ack_o never asserted, m0_stall_o=0 throughout.
- m0_stb_i and m1_stb_i both continuous, MAX_BURST=4, slave 1-cycle ack. Required: repeating pattern of 4 master-0 accepts, then drain, then at least 1 master-1 accept. Each master-1 accept occurs within MAX_BURST+MAX_OUTSTANDING+2 cycles of its request.
- Slave withholds acks, m0 continuous, MAX_OUTSTANDING=4. Required: exactly 4 accepts, then m0_stall_o=1. Releasing one ack allows the 5th accept in that ack cycle.
- Inject s_ack_i with no outstanding transaction. Required: spurious_ack_o pulses 1 cycle, m0_ack_o=m1_ack_o=0, outstanding_q stays 0.
- Assert rst_i low mid-burst with 3 outstanding. Required: stb and ack outputs 0 and stalls 1 immediately, with no clock edge needed. After release, owner=0 and counters are 0, and late acks are flagged spurious.
- m1 read of address 0x40 with slave returning 0xDEADBEEF. Required: m1_ack_o with m_data_o=0xDEADBEEF in the same cycle as s_ack_i.
